// File: rtl/cpu_fetch_unit.sv
// In-order instruction fetch front end; halts after each control transfer until execute resolves it.
// Defining FETCH_PREFETCH_EN adds a one-entry prefetch buffer for back-to-back issue.
module cpu_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned TAG_WIDTH    = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  output logic                 o_bus_request,
  output logic [31:0]          o_bus_address,
  input  logic                 i_bus_ready,
  input  logic [31:0]          i_bus_rdata,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [31:0]          o_instruction,
  output logic [31:0]          o_pc,
  input  logic [TAG_WIDTH-1:0] i_decode_tag,
  input  logic [TAG_WIDTH-1:0] i_branch_tag,
  input  logic [31:0]          i_branch_pc,
  output logic                 o_branch_pending
);

  typedef enum logic [1:0] {FETCH, WAIT_BUS, ISSUE, WAIT_BRANCH} state_t;

  localparam logic [TAG_WIDTH-1:0] TAG_ONE = TAG_WIDTH'(1);

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          word_q, word_d;
  logic                 req_q, req_d;
  logic [31:0]          addr_q, addr_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          opc_q, opc_d;
  logic                 pending_q, pending_d;
  logic [TAG_WIDTH-1:0] issued_q, issued_d;
`ifdef FETCH_PREFETCH_EN
  logic [31:0]          buf_q, buf_d;
  logic                 buf_valid_q, buf_valid_d;
`endif

  logic [TAG_WIDTH-1:0] next_tag;
  logic                 bus_fire;
  logic                 issue_ok;

  function automatic logic is_ct(input logic [6:0] op);
    return (op == 7'b1101111) || (op == 7'b1100111) || (op == 7'b1100011);
  endfunction

  // Tag 0 is reserved for decode's reset value, so the counter skips it on wrap.
  assign next_tag = (tag_q == {TAG_WIDTH{1'b1}}) ? TAG_ONE : tag_q + TAG_ONE;
  assign bus_fire = req_q && i_bus_ready;
  assign issue_ok = (i_decode_tag == tag_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    word_d    = word_q;
    req_d     = req_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    pending_d = pending_q;
    issued_d  = issued_q;
`ifdef FETCH_PREFETCH_EN
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
`endif
    case (state_q)
      FETCH: begin
        req_d   = 1'b1;
        addr_d  = pc_q & 32'hFFFF_FFFC;
        state_d = WAIT_BUS;
      end
      WAIT_BUS: begin
        if (bus_fire) begin
          word_d  = i_bus_rdata;
          req_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef FETCH_PREFETCH_EN
        if (bus_fire) begin
          buf_d       = i_bus_rdata;
          buf_valid_d = 1'b1;
          req_d       = 1'b0;
        end
`endif
        if (issue_ok) begin
          instr_d = word_q;
          opc_d   = pc_q;
          tag_d   = next_tag;
          if (is_ct(word_q[6:0])) begin
            issued_d  = next_tag;
            pending_d = 1'b1;
            state_d   = WAIT_BRANCH;
`ifdef FETCH_PREFETCH_EN
            buf_valid_d = 1'b0;
            req_d       = 1'b0;
`endif
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
`ifdef FETCH_PREFETCH_EN
            // The buffered word or an in-flight read of pc+4 becomes the next head.
            if (buf_valid_q) begin
              word_d      = buf_q;
              buf_valid_d = 1'b0;
              state_d     = ISSUE;
            end else if (bus_fire) begin
              word_d      = i_bus_rdata;
              buf_valid_d = 1'b0;
              req_d       = 1'b0;
              state_d     = ISSUE;
            end else if (req_q) begin
              state_d = WAIT_BUS;
            end
`endif
          end
        end
      end
      WAIT_BRANCH: begin
        if (i_branch_tag == issued_q) begin
          pc_d      = i_branch_pc & 32'hFFFF_FFFC;
          pending_d = 1'b0;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
`ifdef FETCH_PREFETCH_EN
    // Prefetch the successor of the head only when it is sequential and the buffer is free.
    if ((state_d == ISSUE) && !req_d && !buf_valid_d && !is_ct(word_d[6:0])) begin
      req_d  = 1'b1;
      addr_d = (pc_d + 32'd4) & 32'hFFFF_FFFC;
    end
`endif
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      word_q    <= 32'h0;
      req_q     <= 1'b0;
      addr_q    <= RESET_VECTOR & 32'hFFFF_FFFC;
      tag_q     <= '0;
      instr_q   <= 32'h0;
      opc_q     <= 32'h0;
      pending_q <= 1'b0;
      issued_q  <= '0;
`ifdef FETCH_PREFETCH_EN
      buf_q       <= 32'h0;
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      word_q    <= word_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
      instr_q   <= instr_d;
      opc_q     <= opc_d;
      pending_q <= pending_d;
      issued_q  <= issued_d;
`ifdef FETCH_PREFETCH_EN
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
`endif
    end
  end

  assign o_bus_request    = req_q;
  assign o_bus_address    = addr_q;
  assign o_tag            = tag_q;
  assign o_instruction    = instr_q;
  assign o_pc             = opc_q;
  assign o_branch_pending = pending_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit with a latency-configurable bus responder and echoing decode stage.
module tb_cpu_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic [3:0]  o_tag;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic [3:0]  i_decode_tag;
  logic [3:0]  i_branch_tag;
  logic [31:0] i_branch_pc;
  logic        o_branch_pending;

  int vectors;
  int miscompares;

  logic [31:0] mem [0:1023];
  int          bus_lat;
  bit          decode_echo;
  int          force_req;
  int          force_done;
  int          wait_cnt;

  cpu_fetch_unit #(.RESET_VECTOR(32'h0000_0100), .TAG_WIDTH(4)) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .o_bus_request(o_bus_request),
    .o_bus_address(o_bus_address),
    .i_bus_ready(i_bus_ready),
    .i_bus_rdata(i_bus_rdata),
    .o_tag(o_tag),
    .o_instruction(o_instruction),
    .o_pc(o_pc),
    .i_decode_tag(i_decode_tag),
    .i_branch_tag(i_branch_tag),
    .i_branch_pc(i_branch_pc),
    .o_branch_pending(o_branch_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus and decode models drive their inputs 1 time unit after each rising edge.
  initial begin
    i_bus_ready  = 1'b0;
    i_bus_rdata  = 32'h0;
    i_decode_tag = 4'd0;
    wait_cnt     = 0;
    force_done   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (decode_echo) i_decode_tag = o_tag;
      i_bus_ready = 1'b0;
      if (force_req != force_done) begin
        force_done  = force_req;
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hDEAD_BEEF;
      end else if (o_bus_request) begin
        if (wait_cnt >= bus_lat) begin
          i_bus_ready = 1'b1;
          i_bus_rdata = mem[o_bus_address[11:2]];
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic wait_tag_change(input string name, output bit ok);
    logic [3:0] old;
    old = o_tag;
    ok  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_tag !== old) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_issue_timeout: tag stuck at %0d, required a new tag", name, o_tag);
    end else begin
      $display("issue %s: tag=%0d pc=%h instr=%h", name, o_tag, o_pc, o_instruction);
    end
  endtask

  task automatic wait_req(input string name, input logic level);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_bus_request === level) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_req_timeout: request=%b, required %b", name, o_bus_request, level);
    end else begin
      $display("bus %s: request=%b address=%h", name, o_bus_request, o_bus_address);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_bus_request, o_branch_pending} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ctrl: req/pending=%b, required 00", {o_bus_request, o_branch_pending});
    end
    vectors++;
    if ({o_tag, o_instruction, o_pc} !== 68'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: tag=%0d instr=%h pc=%h, required all zero", o_tag, o_instruction, o_pc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    bit ok;
    bus_lat     = 2;
    decode_echo = 1'b1;
    wait_req("first", 1'b1);
    vectors++;
    if (o_bus_address !== 32'h100) begin
      miscompares++;
      $display("FAIL first_addr: got %h, required %h", o_bus_address, 32'h100);
    end
    wait_tag_change("first", ok);
    vectors++;
    if ({o_tag, o_pc, o_instruction} !== {4'd1, 32'h100, 32'h13}) begin
      miscompares++;
      $display("FAIL first_issue: tag=%0d pc=%h instr=%h, required 1/00000100/00000013", o_tag, o_pc, o_instruction);
    end
    wait_req("second", 1'b1);
    vectors++;
    if (o_bus_address !== 32'h104) begin
      miscompares++;
      $display("FAIL second_addr: got %h, required %h", o_bus_address, 32'h104);
    end
  endtask

  task automatic test_decode_stall();
    bit ok;
    decode_echo = 1'b0;
    wait_tag_change("stall", ok);
    vectors++;
    if ({o_tag, o_pc, o_instruction} !== {4'd2, 32'h104, 32'h0010_0093}) begin
      miscompares++;
      $display("FAIL stall_issue: tag=%0d pc=%h instr=%h, required 2/00000104/00100093", o_tag, o_pc, o_instruction);
    end
    wait_req("stall_fetch", 1'b1);
    wait_req("stall_fetch_done", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({o_tag, o_pc, o_bus_request} !== {4'd2, 32'h104, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: tag=%0d pc=%h req=%b, required 2/00000104/0", i, o_tag, o_pc, o_bus_request);
      end
    end
    decode_echo = 1'b1;
  endtask

  task automatic test_branch();
    bit ok;
    wait_tag_change("jal", ok);
    vectors++;
    if ({o_tag, o_pc, o_instruction} !== {4'd3, 32'h108, 32'h0080_00EF}) begin
      miscompares++;
      $display("FAIL jal_issue: tag=%0d pc=%h instr=%h, required 3/00000108/008000ef", o_tag, o_pc, o_instruction);
    end
    vectors++;
    if ({o_branch_pending, o_bus_request} !== 2'b10) begin
      miscompares++;
      $display("FAIL jal_pending: pending/req=%b, required 10", {o_branch_pending, o_bus_request});
    end
    i_branch_tag = 4'd5;
    i_branch_pc  = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({o_branch_pending, o_bus_request, o_tag} !== {2'b10, 4'd3}) begin
        miscompares++;
        $display("FAIL stale_branch%0d: pending=%b req=%b tag=%0d, required 1/0/3", i, o_branch_pending, o_bus_request, o_tag);
      end
    end
    i_branch_tag = 4'd3;
    i_branch_pc  = 32'h203;
    wait_req("branch_target", 1'b1);
    vectors++;
    if ({o_bus_address, o_branch_pending} !== {32'h200, 1'b0}) begin
      miscompares++;
      $display("FAIL branch_target: addr=%h pending=%b, required 00000200/0", o_bus_address, o_branch_pending);
    end
  endtask

  task automatic test_tag_wrap();
    bit ok;
    int exp_tag;
    bus_lat = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tag_change("wrap", ok);
      exp_tag = (4 + i > 15) ? (4 + i - 15) : (4 + i);
      vectors++;
      if ({o_tag, o_pc} !== {exp_tag[3:0], 32'h200 + 32'(4 * i)}) begin
        miscompares++;
        $display("FAIL wrap%0d: tag=%0d pc=%h, required %0d/%h", i, o_tag, o_pc, exp_tag, 32'h200 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus_lat = 5;
    wait_req("mid", 1'b1);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_bus_request, o_branch_pending, o_tag, o_instruction, o_pc} !== 70'h0) begin
      miscompares++;
      $display("FAIL mid_reset: req=%b pending=%b tag=%0d instr=%h pc=%h, required all zero",
               o_bus_request, o_branch_pending, o_tag, o_instruction, o_pc);
    end
    i_branch_tag = 4'd0;
    @(negedge clk);
    force_req++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_req("mid_restart", 1'b1);
    vectors++;
    if (o_bus_address !== 32'h100) begin
      miscompares++;
      $display("FAIL mid_restart_addr: got %h, required %h", o_bus_address, 32'h100);
    end
    wait_tag_change("mid_restart", ok);
    vectors++;
    if ({o_tag, o_pc, o_instruction} !== {4'd1, 32'h100, 32'h13}) begin
      miscompares++;
      $display("FAIL mid_restart_issue: tag=%0d pc=%h instr=%h, required 1/00000100/00000013", o_tag, o_pc, o_instruction);
    end
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic test_back_to_back();
    bit ok;
    rst_n        = 1'b0;
    i_branch_tag = 4'd0;
    bus_lat      = 0;
    mem[32'h108 >> 2] = 32'h0000_0063;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tag_change("b2b", ok);
    vectors++;
    if ({o_tag, o_pc} !== {4'd1, 32'h100}) begin
      miscompares++;
      $display("FAIL b2b_first: tag=%0d pc=%h, required 1/00000100", o_tag, o_pc);
    end
    @(negedge clk);
    vectors++;
    if ({o_tag, o_pc} !== {4'd2, 32'h104}) begin
      miscompares++;
      $display("FAIL b2b_second: tag=%0d pc=%h, required 2/00000104", o_tag, o_pc);
    end
    @(negedge clk);
    vectors++;
    if ({o_tag, o_pc, o_instruction, o_branch_pending} !== {4'd3, 32'h108, 32'h63, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_branch: tag=%0d pc=%h instr=%h pending=%b, required 3/00000108/00000063/1",
               o_tag, o_pc, o_instruction, o_branch_pending);
    end
    i_branch_tag = 4'd3;
    i_branch_pc  = 32'h208;
    wait_tag_change("b2b_target", ok);
    vectors++;
    if ({o_tag, o_pc} !== {4'd4, 32'h208}) begin
      miscompares++;
      $display("FAIL b2b_target: tag=%0d pc=%h, required 4/00000208", o_tag, o_pc);
    end
  endtask
`endif

  initial begin
    vectors      = 0;
    miscompares  = 0;
    force_req    = 0;
    bus_lat      = 2;
    decode_echo  = 1'b1;
    rst_n        = 1'b0;
    i_branch_tag = 4'd0;
    i_branch_pc  = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
    mem[32'h104 >> 2] = 32'h0010_0093;
    mem[32'h108 >> 2] = 32'h0080_00EF;

    test_reset();
    test_first_fetch();
    test_decode_stall();
    test_branch();
    test_tag_wrap();
    test_reset_mid();
`ifdef FETCH_PREFETCH_EN
    test_back_to_back();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
